// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared definitions for the sequential BNN classifier: the
//               control FSM state encoding and width helper functions used
//               to size the class counters, index registers and the
//               hidden-neuron accumulators.
// Contents    : state_t        - IDLE / HIDDEN / ARGMAX / DONE
//               sum_w(m)       - width of a popcount over m neurons
//               ium_w(n, b)    - width of a sum of n b-bit features
//               idx_w(x)       - width of an index into x items (min 1)
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIDDEN = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Popcount of up to m set bits.
  function automatic int sum_w(input int m);
    return $clog2(m + 1);
  endfunction

  // Sum of up to n unsigned b-bit operands, never overflows.
  function automatic int ium_w(input int n, input int b);
    return $clog2(n + 1) + b;
  endfunction

  // Index register width; a single-entry range still needs one bit.
  function automatic int idx_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_neuron_eval.sv
`default_nettype none
// ============================================================================
// Module      : bnn_neuron_eval
// Description : Purely combinational evaluation of one binary hidden neuron.
//               Features whose mask bit is 1 go to the positive sum, the
//               rest to the negative sum; mid = (pos >= neg), ties give 1.
// Ports       : sample [N*B-1:0] in  packed features, inm[0] in the MS slice
//               w_row  [N-1:0]   in  sign mask row; bit i belongs to inm[i]
//               mid              out neuron output bit
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_neuron_eval
  import bnn_pkg::*;
#(
  parameter int N = 11,
  parameter int B = 4
) (
  input  logic [N*B-1:0] sample,
  input  logic [N-1:0]   w_row,
  output logic           mid
);

  localparam int IW = ium_w(N, B);

  logic [IW-1:0] pos_sum;
  logic [IW-1:0] neg_sum;

  // Feature i lives at sample[(N-1-i)*B +: B] because inm[0] is the MS slice.
  always_comb begin
    pos_sum = '0;
    neg_sum = '0;
    for (int i = 0; i < N; i++) begin
      if (w_row[i]) pos_sum = pos_sum + IW'(sample[(N-1-i)*B +: B]);
      else          neg_sum = neg_sum + IW'(sample[(N-1-i)*B +: B]);
    end
    mid = (pos_sum >= neg_sum);
  end

endmodule
`default_nettype wire

// File: rtl/bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
// Module      : bnn_seq_classifier
// Description : Sequential binary neural network classifier. One hidden
//               neuron is evaluated per clock while C class popcounts are
//               accumulated; the argmax is then resolved serially (lowest
//               index wins ties) and returned over a valid/ready handshake.
// Ports       : clk                 in  clock, rising edge
//               rst_n               in  asynchronous active-low reset
//               in_valid / in_ready in/out sample handshake (ready in IDLE)
//               inp [N*B-1:0]       in  packed features, inm[0] is MS slice
//               out_valid/out_ready out/in result handshake (valid in DONE)
//               klass [$clog2(C)]   out winning class index
//               score [$clog2(M+1)] out popcount of the winning class
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int             N  = 11,
  parameter int             M  = 40,
  parameter int             B  = 4,
  parameter int             C  = 7,
  parameter logic [M*N-1:0] W1 = '0,
  parameter logic [C*M-1:0] W2 = '0,
  localparam int            KW = idx_w(C),
  localparam int            SW = sum_w(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*B-1:0] inp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [KW-1:0]  klass,
  output logic [SW-1:0]  score
);

  localparam int JW = idx_w(M);

  state_t          state;
  state_t          state_nxt;
  logic [N*B-1:0]  sample;
  logic [JW-1:0]   j;
  logic [KW-1:0]   k;
  logic [KW-1:0]   best_idx;
  logic [SW-1:0]   best_score;
  logic [SW-1:0]   cnt [C];
  logic [N-1:0]    w1_rows [M];
  logic            mid;
  logic            accept;
  logic            last_j;
  logic            last_k;
  logic            take;

  // Unpack W1 into per-neuron rows so the running index selects a row.
  for (genvar jj = 0; jj < M; jj++) begin : g_w1_row
    assign w1_rows[jj] = W1[jj*N +: N];
  end

  bnn_neuron_eval #(
    .N (N),
    .B (B)
  ) u_neuron (
    .sample (sample),
    .w_row  (w1_rows[j]),
    .mid    (mid)
  );

  assign accept = in_valid & in_ready;
  assign last_j = (j == JW'(M - 1));
  assign last_k = (k == KW'(C - 1));
  // Index 0 seeds the running best; later entries replace it only when
  // strictly greater so the lowest index keeps a tie.
  assign take   = (k == '0) || (cnt[k] > best_score);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HIDDEN;
      end
      HIDDEN: if (last_j) state_nxt = ARGMAX;
      ARGMAX: if (last_k) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sample register, neuron/argmax indices and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample     <= '0;
      j          <= '0;
      k          <= '0;
      best_idx   <= '0;
      best_score <= '0;
      klass      <= '0;
      score      <= '0;
    end else begin
      if (accept) begin
        sample <= inp;
        j      <= '0;
      end
      if (state == HIDDEN) begin
        if (last_j) begin
          j <= '0;
          k <= '0;
        end else begin
          j <= j + JW'(1);
        end
      end
      if (state == ARGMAX) begin
        if (!last_k) k <= k + KW'(1);
        if (take) begin
          best_idx   <= k;
          best_score <= cnt[k];
        end
        // The final comparison is folded straight into the result registers.
        if (last_k) begin
          klass <= take ? k      : best_idx;
          score <= take ? cnt[k] : best_score;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Class popcounts: class c counts mid where its W2 bit is 1, ~mid where 0.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < C; c++) begin : g_cnt
    localparam logic [M-1:0] ROW = W2[c*M +: M];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                cnt[c] <= '0;
      else if (accept)                           cnt[c] <= '0;
      else if (state == HIDDEN && mid == ROW[j]) cnt[c] <= cnt[c] + SW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_seq_classifier
// Description : Self-checking bench for bnn_seq_classifier. Two small
//               instances (N=2, M=1, C=2) share stimulus and differ in W2;
//               one default-size instance (N=11, M=40, C=7) uses fixed
//               pseudo-random masks. Expected results come from a
//               behavioural reference model through per-instance queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_seq_classifier;

  localparam logic [439:0] W1G = {
    32'hA5C3_96E1, 32'h1F2E_3D4C, 32'h9B8A_7766, 32'h0F0F_33CC,
    32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321, 32'hC0FF_EE11,
    32'h5A5A_A5A5, 32'h7E81_3C42, 32'hB00B_1E55, 32'h2468_ACE0,
    32'h1357_9BDF, 24'h6D_92F3};
  localparam logic [279:0] W2G = {
    32'h3C96_5AE1, 32'hF00D_CAFE, 32'h9E37_79B9, 32'h4F1B_BCDC,
    32'h0123_4567, 32'hA1B2_C3D4, 32'h55AA_33CC, 32'hE7D3_1A0F,
    24'h8B_4C2D};
  localparam logic [439:0] W1S  = 440'b01;
  localparam logic [279:0] W2SA = 280'b10;
  localparam logic [279:0] W2SB = 280'b11;

  typedef struct packed {
    logic [2:0] k;
    logic [5:0] s;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        s_in_valid, s_out_ready;
  logic [7:0]  s_inp;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [0:0]  a_klass, a_score, b_klass, b_score;
  logic        g_in_valid, g_out_ready, g_in_ready, g_out_valid;
  logic [43:0] g_inp;
  logic [2:0]  g_klass;
  logic [5:0]  g_score;

  int   checks   = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qg[$];

  bnn_seq_classifier #(.N(2), .M(1), .B(4), .C(2), .W1(2'b01), .W2(2'b10)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(a_in_ready),
    .inp(s_inp), .out_valid(a_out_valid), .out_ready(s_out_ready),
    .klass(a_klass), .score(a_score));

  bnn_seq_classifier #(.N(2), .M(1), .B(4), .C(2), .W1(2'b01), .W2(2'b11)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .inp(s_inp), .out_valid(b_out_valid), .out_ready(s_out_ready),
    .klass(b_klass), .score(b_score));

  bnn_seq_classifier #(.N(11), .M(40), .B(4), .C(7), .W1(W1G), .W2(W2G)) dut_g (
    .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .inp(g_inp), .out_valid(g_out_valid), .out_ready(g_out_ready),
    .klass(g_klass), .score(g_score));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference model (4-bit features): inm[0] is the MS slice of x.
  function automatic exp_t golden(input int n, input int m, input int c,
                                  input logic [439:0] w1, input logic [279:0] w2,
                                  input logic [43:0] x);
    int   inm [11];
    int   cnt [7];
    int   pos, neg, best;
    bit   mid;
    logic [43:0] t;
    exp_t r;
    for (int cc = 0; cc < 7; cc++) cnt[cc] = 0;
    for (int i = 0; i < n; i++) begin
      t = x >> ((n - 1 - i) * 4);
      inm[i] = int'(t[3:0]);
    end
    for (int jj = 0; jj < m; jj++) begin
      pos = 0;
      neg = 0;
      for (int i = 0; i < n; i++) begin
        if (w1[jj*n+i]) pos += inm[i];
        else            neg += inm[i];
      end
      mid = (pos >= neg);
      for (int cc = 0; cc < c; cc++)
        if (w2[cc*m+jj] == mid) cnt[cc]++;
    end
    best = 0;
    for (int cc = 1; cc < c; cc++)
      if (cnt[cc] > cnt[best]) best = cc;
    r.k = 3'(best);
    r.s = 6'(cnt[best]);
    return r;
  endfunction

  // Small pair: one sample, optional DONE backpressure with an injected
  // in_valid that must be ignored. Entered and left at a falling edge.
  task automatic run_small(input logic [7:0] x, input int bp_cycles);
    exp_t ea, eb;
    int   lat;
    logic [0:0] k0, s0;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      failures++; $display("FAIL small_in_ready_idle got=%b%b exp=11", a_in_ready, b_in_ready);
    end
    s_in_valid = 1'b1; s_inp = x; s_out_ready = 1'b0;
    @(posedge clk);
    qa.push_back(golden(2, 1, 2, W1S, W2SA, {36'b0, x}));
    qb.push_back(golden(2, 1, 2, W1S, W2SB, {36'b0, x}));
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++; $display("FAIL small_in_ready_after_accept got=%b exp=0", a_in_ready);
    end
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end
    while (a_out_valid !== 1'b1 && lat < 200);
    checks++;
    if (lat != 3 || b_out_valid !== 1'b1) begin
      failures++; $display("FAIL small_latency got=%0d exp=3 (b_valid=%b)", lat, b_out_valid);
    end
    ea = qa.pop_front();
    eb = qb.pop_front();
    if (a_out_valid !== 1'b1) return;
    checks++;
    if ({2'b0, a_klass} !== ea.k || {5'b0, a_score} !== ea.s) begin
      failures++; $display("FAIL small_a_result x=%h got k=%0d s=%0d exp k=%0d s=%0d", x, a_klass, a_score, ea.k, ea.s);
    end
    checks++;
    if ({2'b0, b_klass} !== eb.k || {5'b0, b_score} !== eb.s) begin
      failures++; $display("FAIL small_b_result x=%h got k=%0d s=%0d exp k=%0d s=%0d", x, b_klass, b_score, eb.k, eb.s);
    end
    k0 = a_klass; s0 = a_score;
    for (int i = 0; i < bp_cycles; i++) begin
      s_in_valid = 1'b1; s_inp = ~x;
      @(posedge clk); @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_klass !== k0 || a_score !== s0 || a_in_ready !== 1'b0) begin
        failures++; $display("FAIL small_backpressure cyc=%0d got v=%b k=%0d s=%0d rdy=%b exp v=1 k=%0d s=%0d rdy=0",
                             i, a_out_valid, a_klass, a_score, a_in_ready, k0, s0);
      end
    end
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    s_out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++; $display("FAIL small_release got rdy=%b v=%b exp rdy=1 v=0", a_in_ready, a_out_valid);
    end
  endtask

  // Default-size instance: one sample, latency and result checked,
  // random or immediate out_ready. Entered and left at a falling edge.
  task automatic run_big(input logic [43:0] x, input bit rand_ready);
    exp_t e;
    int   lat, tries;
    bit   hs;
    logic [2:0] k0;
    logic [5:0] s0;
    checks++;
    if (g_in_ready !== 1'b1) begin
      failures++; $display("FAIL big_in_ready_idle got=%b exp=1", g_in_ready);
    end
    g_in_valid = 1'b1; g_inp = x;
    @(posedge clk);
    qg.push_back(golden(11, 40, 7, W1G, W2G, x));
    @(negedge clk);
    g_in_valid = 1'b0; g_inp = '0;
    checks++;
    if (g_in_ready !== 1'b0) begin
      failures++; $display("FAIL big_in_ready_after_accept got=%b exp=0", g_in_ready);
    end
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end
    while (g_out_valid !== 1'b1 && lat < 200);
    checks++;
    if (lat != 47) begin
      failures++; $display("FAIL big_latency x=%h got=%0d exp=47", x, lat);
    end
    e = qg.pop_front();
    if (g_out_valid !== 1'b1) return;
    checks++;
    if (g_klass !== e.k) begin
      failures++; $display("FAIL big_klass x=%h got=%0d exp=%0d", x, g_klass, e.k);
    end
    checks++;
    if (g_score !== e.s) begin
      failures++; $display("FAIL big_score x=%h got=%0d exp=%0d", x, g_score, e.s);
    end
    k0 = g_klass; s0 = g_score; tries = 0;
    do begin
      g_out_ready = (rand_ready && tries < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = g_out_ready;
      @(posedge clk); @(negedge clk);
      tries++;
      if (!hs) begin
        checks++;
        if (g_out_valid !== 1'b1 || g_klass !== k0 || g_score !== s0 || g_in_ready !== 1'b0) begin
          failures++; $display("FAIL big_hold got v=%b k=%0d s=%0d rdy=%b exp v=1 k=%0d s=%0d rdy=0",
                               g_out_valid, g_klass, g_score, g_in_ready, k0, s0);
        end
      end
    end while (!hs);
    g_out_ready = 1'b0;
    checks++;
    if (g_in_ready !== 1'b1 || g_out_valid !== 1'b0) begin
      failures++; $display("FAIL big_release got rdy=%b v=%b exp rdy=1 v=0", g_in_ready, g_out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_klass !== 1'b0 || a_score !== 1'b0) begin
      failures++; $display("FAIL reset_small got rdy=%b v=%b k=%0d s=%0d exp 1 0 0 0", a_in_ready, a_out_valid, a_klass, a_score);
    end
    checks++;
    if (g_in_ready !== 1'b1 || g_out_valid !== 1'b0 || g_klass !== 3'd0 || g_score !== 6'd0) begin
      failures++; $display("FAIL reset_big got rdy=%b v=%b k=%0d s=%0d exp 1 0 0 0", g_in_ready, g_out_valid, g_klass, g_score);
    end
  endtask

  task automatic test_decision();
    run_small(8'h53, 0);  // 5 vs 3 -> mid=1 -> class 1
    run_small(8'h35, 0);  // 3 vs 5 -> mid=0 -> class 0
  endtask

  task automatic test_tie();
    run_small(8'h44, 0);  // equal sums: mid=1; B has both classes at 1 -> 0
  endtask

  task automatic test_backpressure();
    run_small(8'h53, 10);
    repeat (5) @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL ignored_input got v=%b rdy=%b exp v=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_big({12'($urandom), $urandom}, 1'b0);
    g_in_valid = 1'b1; g_inp = {12'($urandom), $urandom};
    @(posedge clk);
    @(negedge clk);
    g_in_valid = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (g_in_ready !== 1'b1 || g_out_valid !== 1'b0 || g_klass !== 3'd0 || g_score !== 6'd0) begin
      failures++; $display("FAIL reset_mid got rdy=%b v=%b k=%0d s=%0d exp 1 0 0 0", g_in_ready, g_out_valid, g_klass, g_score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (g_out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL reset_partial_emitted got=1 exp=0");
    end
    run_big({12'($urandom), $urandom}, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_big(44'h0, 1'b1);
    run_big({44{1'b1}}, 1'b1);
    for (int i = 0; i < 998; i++) run_big({12'($urandom), $urandom}, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_inp = '0;
    g_in_valid = 1'b0; g_out_ready = 1'b0; g_inp = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_decision();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bnn_seq_classifier.md
# bnn_seq_classifier

Sequential, parametrised successor to the flat combinational BNN classifiers. It evaluates one binary hidden neuron per clock and accumulates the C class popcounts incrementally. It then resolves the argmax serially and returns the class index over a valid/ready handshake. It trades the fully parallel adder trees for roughly N adders plus C small counters, so larger M and C fit in small devices.

## Interface
- N, 11: input features.
- M, 40: hidden binary neurons.
- B, 4: bits per unsigned input feature.
- C, 7: output classes.
- W1, 0: M*N-bit hidden sign mask. Bit [j*N+i]=1 means feature i adds to neuron j's positive sum; 0 means it adds to the negative sum.
- W2, 0: C*M-bit output mask. Bit [c*M+j]=1 means class c counts mid[j]; 0 means it counts ~mid[j].
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample.
- inp  in  N*B  packed features: feature inm[N-1-i] = inp[i*B+:B], so inm[0] is the MS slice.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- klass  out  $clog2(C)  winning class index.
- score  out  $clog2(M+1)  popcount of the winning class.

## Operation
- Local widths: SumL=$clog2(M+1) and IumL=$clog2(N+1)+B. All sums are unsigned and must not overflow.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch inp into a sample register, clear the neuron counter j and all C class counters, then go to HIDDEN.
  - HIDDEN: each cycle, compute pos_j as the sum of features with W1 bit 1 and neg_j as the sum with W1 bit 0. mid = (pos_j >= neg_j); ties give 1. For each c, increment cnt[c] if mid == W2[c*M+j]. Increment j. After j=M-1, clear the argmax index k and go to ARGMAX.
  - ARGMAX: each cycle, compare cnt[k] against the running best. Index 0 initialises the best. Replace the best only on strictly greater, so the lowest index wins ties. After k=C-1, register klass/score and go to DONE.
  - DONE: out_valid=1, with klass/score held stable. On out_ready, go to IDLE.
- in_ready is asserted only in IDLE. in_valid in any other state is ignored and not queued.
- Degenerate shapes: with M=1, HIDDEN lasts one cycle. With C=1, ARGMAX lasts one cycle and klass=0.
- Reset (at any time, including mid-sample): state goes to IDLE, counters and sample register clear to 0, in_ready=1, out_valid=0, klass=0, score=0. A partial result is discarded and never emitted.

## Timing
- Latency: the accept edge is edge 0. HIDDEN occupies edges 1..M. ARGMAX occupies edges M+1..M+C. out_valid rises after edge M+C.
- Throughput: one sample per M+C+2 cycles when out_ready is held high. This is accept, M+C processing cycles, one DONE cycle, then IDLE.
- DONE holds indefinitely under backpressure; outputs must not change while out_valid=1 and out_ready=0.
- in_ready is low on the cycle after the accept edge.
- in_ready returns high the cycle after the out_valid&out_ready edge.
- The hidden-neuron adder path, N B-bit operands into an IumL compare, is the only wide combinational path. It must meet timing without a pipeline stage.

## Structure
- Shared package bnn_pkg holds:
  - the state enum (IDLE, HIDDEN, ARGMAX, DONE);
  - width functions for SumL and IumL.
- Natural sub-module: bnn_neuron_eval. It is purely combinational: inputs are the sample and the N-bit W1 row, output is mid.
- The class counters and the serial argmax stay in the top level.

## Test plan
All scenarios use N=2, M=1, B=4, C=2, W1=2'b01 (feature 0 positive, feature 1 negative), W2=2'b10 (class 1 counts mid, class 0 counts ~mid) unless a scenario overrides it.
- Decision on mid: inm0=5, inm1=3 (inp=8'h53) -> klass=1, score=1, out_valid exactly 3 edges after accept. inm0=3, inm1=5 (inp=8'h35) -> klass=0, score=1.
- Equality and tie-break: inm0=inm1=4 -> mid=1, klass=1. With W2=2'b11 and the same input, both scores are 1 -> klass=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, klass/score stable, in_ready=0, a second in_valid is ignored. Releasing out_ready -> in_ready=1 on the next cycle.
- Reset mid-HIDDEN (defaults N=11, M=40, C=7, random masks): assert rst_n=0 at HIDDEN cycle 17 -> outputs 0 and in_ready=1 immediately. The next sample produces a result matching the golden model.
- Back-to-back random regression at defaults: 1000 samples with random out_ready -> every klass/score matches a combinational reference model, and each latency equals M+C=47 edges from accept to out_valid.
